instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Multi-cycle fetch stage that sits between the PC/next-instruction unit and the Avalon-MM instruction memory port.
- During the PC unit's FETCH state it issues one word read at the current PC and waits out `avm_waitrequest`.
- It drives the PC unit's `STALL` input, then latches the returned word into an instruction register.
- It publishes the decoded branch/jump fields (rs index, rt index, imm16, target26) that the PC unit and register file consume in EXEC1/EXEC2.

Parameters:
- BYTE_SWAP, 1: 1 = memory returns little-endian byte lanes and instruction word is byte-reversed before latching; 0 = pass through.
- COUNT_W, 32: width of completed-fetch counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pc_in  input  32  current PC from PC unit
- fetch_req  input  1  high while PC unit is in FETCH state (state==0)
- active_in  input  1  CPU active; fetches suppressed when 0
- avm_address  output  32  Avalon read address
- avm_read  output  1  Avalon read strobe
- avm_byteenable  output  4  always 4'b1111 while avm_read=1, else 4'b0000
- avm_waitrequest  input  1  Avalon wait
- avm_readdata  input  32  Avalon read data
- stall  output  1  to PC unit STALL; holds it in FETCH
- instr_out  output  32  instruction register
- instr_valid  output  1  one-cycle pulse, IR loaded this cycle
- rs_idx  output  5  instr_out[25:21]
- rt_idx  output  5  instr_out[20:16]
- imm16  output  16  instr_out[15:0]
- target26  output  26  instr_out[25:0]
- fetch_fault  output  1  sticky misaligned-PC flag
- fetch_count  output  COUNT_W  completed fetches, wraps at 2^COUNT_W

Behaviour:
- States:
  - IDLE: no read outstanding.
  - REQ: read outstanding.
  - HOLD: IR valid, waiting for fetch_req to drop.
- Reset values: state=IDLE, avm_read=0, avm_address=0, instr_out=0, instr_valid=0, fetch_fault=0, fetch_count=0.
- Reset timing: rst wins over all other inputs on the same edge. Reset during REQ drops avm_read at that edge; the pending readdata is discarded.
- IDLE, fetch_req=1, active_in=1, pc_in[1:0]==0: register avm_address<=pc_in, avm_read<=1, go to REQ.
- IDLE, fetch_req=1, active_in=1, pc_in[1:0]!=0: no bus read. instr_out<=0 (NOP), fetch_fault<=1, instr_valid pulse, go to HOLD.
- IDLE, active_in=0: ignore fetch_req, stay IDLE.
- REQ, avm_waitrequest=1: hold avm_address and avm_read stable (Avalon rule).
- REQ, avm_waitrequest=0: capture readdata (byte-reversed if BYTE_SWAP) into instr_out, avm_read<=0, instr_valid pulse next cycle, fetch_count+1, go to HOLD.
- HOLD: fetch_req=0 -> IDLE. fetch_req=1 (PC unit still in FETCH) -> stay, no new read.
- stall (combinational):
  - 1 when state==IDLE & fetch_req & active_in.
  - 1 when state==REQ & avm_waitrequest.
  - 0 otherwise.
- Stall timing: stall drops in the REQ cycle where waitrequest=0, so the PC unit leaves FETCH on the same edge the IR is loaded. In the misaligned case stall is high one cycle only (the IDLE cycle).
- Minimum latency: fetch_req rise to IR loaded = 2 edges. Each waitrequest cycle adds 1.
- Decoded fields are pure slices of instr_out, so they are stable from IR load until the next IR load. instr_out holds its value across EXEC1/EXEC2.
- fetch_fault clears only on rst.
- fetch_count wraps silently.

Test Plan:
- Zero-wait fetch: rst, pc_in=32'hBFC00000, fetch_req=1, waitrequest=0, readdata=32'h0C000010, BYTE_SWAP=0 -> avm_read high exactly 1 cycle at addr BFC00000; stall high 1 cycle; instr_out=0C000010, target26=26'h0000010, instr_valid pulse; fetch_count=1.
- Wait states: waitrequest=1 for 3 cycles then 0 -> avm_address/avm_read stable for all 4 REQ cycles; stall high for 4 cycles total; IR loads on the 5th edge.
- Byte swap: BYTE_SWAP=1, readdata=32'h78563412 -> instr_out=12345678, rs_idx=5'h11, rt_idx=5'h14, imm16=16'h5678.
- Misaligned PC: pc_in=32'hBFC00002, fetch_req=1 -> no avm_read; instr_out=0; fetch_fault=1 and stays 1 over 3 further aligned fetches until rst.
- Reset mid-read: assert rst in 2nd REQ cycle with waitrequest=1 -> next cycle avm_read=0, state IDLE, instr_out=0; subsequent fetch at BFC00004 completes normally.
- Inactive/back-to-back: active_in=0 with fetch_req=1 -> no read, stall=0. Two consecutive fetch_req windows at BFC00000, BFC00004 -> exactly one read each; HOLD blocks a re-read while fetch_req stays high.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle instruction fetch stage on an Avalon-MM read port
module instr_fetch_unit #(
    parameter int BYTE_SWAP = 1,
    parameter int COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic               fetch_req,
    input  logic               active_in,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    output logic [3:0]         avm_byteenable,
    input  logic               avm_waitrequest,
    input  logic [31:0]        avm_readdata,
    output logic               stall,
    output logic [31:0]        instr_out,
    output logic               instr_valid,
    output logic [4:0]         rs_idx,
    output logic [4:0]         rt_idx,
    output logic [15:0]        imm16,
    output logic [25:0]        target26,
    output logic               fetch_fault,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        start;
    logic        aligned;
    logic [31:0] read_word;

    assign start   = fetch_req & active_in;
    assign aligned = (pc_in[1:0] == 2'b00);

    // Memory hands back little-endian lanes; reverse them so the IR holds the big-endian word.
    assign read_word = (BYTE_SWAP != 0)
        ? {avm_readdata[7:0], avm_readdata[15:8], avm_readdata[23:16], avm_readdata[31:24]}
        : avm_readdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_next = aligned ? REQ : HOLD;
                end
            end
            REQ: begin
                if (avm_waitrequest) begin
                    stall = 1'b1;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!fetch_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avm_address <= 32'd0;
            avm_read    <= 1'b0;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (aligned) begin
                            avm_address <= pc_in;
                            avm_read    <= 1'b1;
                        end else begin
                            // Misaligned PC: hand the PC unit a NOP instead of touching the bus.
                            instr_out   <= 32'd0;
                            instr_valid <= 1'b1;
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        instr_out   <= read_word;
                        avm_read    <= 1'b0;
                        instr_valid <= 1'b1;
                        fetch_count <= fetch_count + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign avm_byteenable = avm_read ? 4'b1111 : 4'b0000;

    assign rs_idx   = instr_out[25:21];
    assign rt_idx   = instr_out[20:16];
    assign imm16    = instr_out[15:0];
    assign target26 = instr_out[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        fetch_req = 1'b0;
    logic        active_in = 1'b1;
    logic        waitreq = 1'b0;
    logic [31:0] readdata = 32'd0;

    logic [31:0] addr0, addr1, instr0, instr1;
    logic        read0, read1, stall0, stall1, valid0, valid1, fault0, fault1;
    logic [3:0]  be0, be1;
    logic [4:0]  rs0, rs1, rt0, rt1;
    logic [15:0] imm0, imm1;
    logic [25:0] tgt0, tgt1;
    logic [31:0] cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;
    logic exp_fault = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.BYTE_SWAP(0), .COUNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_req(fetch_req), .active_in(active_in),
        .avm_address(addr0), .avm_read(read0), .avm_byteenable(be0),
        .avm_waitrequest(waitreq), .avm_readdata(readdata), .stall(stall0),
        .instr_out(instr0), .instr_valid(valid0), .rs_idx(rs0), .rt_idx(rt0),
        .imm16(imm0), .target26(tgt0), .fetch_fault(fault0), .fetch_count(cnt0)
    );

    instr_fetch_unit #(.BYTE_SWAP(1), .COUNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_req(fetch_req), .active_in(active_in),
        .avm_address(addr1), .avm_read(read1), .avm_byteenable(be1),
        .avm_waitrequest(waitreq), .avm_readdata(readdata), .stall(stall1),
        .instr_out(instr1), .instr_valid(valid1), .rs_idx(rs1), .rt_idx(rt1),
        .imm16(imm1), .target26(tgt1), .fetch_fault(fault1), .fetch_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    task automatic check_idle_bus(input string tag);
        chk({tag, "_read0"}, 32'(read0), 32'd0);
        chk({tag, "_read1"}, 32'(read1), 32'd0);
        chk({tag, "_be"}, 32'(be1), 32'd0);
    endtask

    // One aligned fetch window: IDLE cycle, 1+nwait REQ cycles, then HOLD while fetch_req stays high.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int nwait);
        int stall_cycles = 0;
        @(negedge clk);
        pc_in = pc; fetch_req = 1'b1; active_in = 1'b1; waitreq = 1'($urandom);
        #1;
        check_idle_bus("idle");
        chk("idle_stall", 32'(stall1), 32'd1);
        stall_cycles += int'(stall1);
        for (int k = 1; k <= nwait + 1; k++) begin
            @(negedge clk);
            waitreq = (k <= nwait);
            readdata = (k <= nwait) ? $urandom : data;
            #1;
            chk("req_read0", 32'(read0), 32'd1);
            chk("req_read1", 32'(read1), 32'd1);
            chk("req_addr", addr1, pc);
            chk("req_be", 32'(be1), 32'hF);
            chk("req_stall", 32'(stall0), 32'(k <= nwait));
            stall_cycles += int'(stall0);
        end
        exp_count++;
        @(negedge clk);
        waitreq = 1'($urandom); readdata = $urandom;
        #1;
        check_idle_bus("load");
        chk("stall_total", stall_cycles, nwait + 1);
        chk("load_valid0", 32'(valid0), 32'd1);
        chk("load_valid1", 32'(valid1), 32'd1);
        chk("load_instr0", instr0, data);
        chk("load_instr1", instr1, bswap(data));
        chk("load_rs", 32'(rs1), 32'(bswap(data) >> 21) & 32'h1F);
        chk("load_rt", 32'(rt1), 32'(bswap(data) >> 16) & 32'h1F);
        chk("load_imm", 32'(imm1), bswap(data) & 32'hFFFF);
        chk("load_tgt", 32'(tgt0), data & 32'h03FF_FFFF);
        chk("count0", cnt0, 32'(exp_count));
        chk("count1", 32'(cnt1), 32'(exp_count % 8));
        chk("fault", 32'(fault1), 32'(exp_fault));
        chk("hold_stall", 32'(stall1), 32'd0);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            #1;
            check_idle_bus("hold");
            chk("hold_valid", 32'(valid1), 32'd0);
            chk("hold_instr", instr0, data);
        end
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic do_misaligned(input logic [31:0] pc);
        @(negedge clk);
        pc_in = pc; fetch_req = 1'b1; active_in = 1'b1;
        #1;
        chk("mis_stall", 32'(stall1), 32'd1);
        check_idle_bus("mis_idle");
        exp_fault = 1'b1;
        @(negedge clk);
        #1;
        check_idle_bus("mis_hold");
        chk("mis_stall_after", 32'(stall1), 32'd0);
        chk("mis_valid", 32'(valid0), 32'd1);
        chk("mis_instr0", instr0, 32'd0);
        chk("mis_instr1", instr1, 32'd0);
        chk("mis_fault0", 32'(fault0), 32'd1);
        chk("mis_count", cnt0, 32'(exp_count));
        @(negedge clk);
        #1;
        chk("mis_valid_drop", 32'(valid0), 32'd0);
        check_idle_bus("mis_hold2");
        fetch_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        repeat (2) @(negedge clk);
        #1;
        check_idle_bus("rst");
        chk("rst_addr", addr0, 32'd0);
        chk("rst_instr", instr0, 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_fault", 32'(fault0), 32'd0);
        chk("rst_count", cnt0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_fetch(32'hBFC0_0000, 32'h0C00_0010, 0);
        chk("zw_target26", 32'(tgt0), 32'h0000_0010);
        do_fetch(32'hBFC0_0004, 32'h7856_3412, 3);
        chk("bs_instr", instr1, 32'h1234_5678);
        chk("bs_rs", 32'(rs1), 32'h11);
        chk("bs_rt", 32'(rt1), 32'h14);
        chk("bs_imm", 32'(imm1), 32'h5678);

        // Inactive CPU: fetch_req is ignored entirely.
        @(negedge clk);
        active_in = 1'b0; fetch_req = 1'b1; pc_in = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("inact_stall", 32'(stall0), 32'd0);
            check_idle_bus("inact");
            @(negedge clk);
        end
        fetch_req = 1'b0; active_in = 1'b1;

        do_misaligned(32'hBFC0_0002);
        for (int i = 0; i < 3; i++) do_fetch(32'hBFC0_0010 + 32'(4 * i), $urandom, $urandom_range(0, 2));

        // Reset on the second REQ cycle while the slave is still waiting.
        @(negedge clk);
        pc_in = 32'hBFC0_0020; fetch_req = 1'b1; waitreq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fetch_req = 1'b0;
        exp_count = 0; exp_fault = 1'b0;
        #1;
        check_idle_bus("mid_rst");
        chk("mid_rst_instr", instr0, 32'd0);
        chk("mid_rst_fault", 32'(fault0), 32'd0);
        chk("mid_rst_count", cnt0, 32'd0);
        chk("mid_rst_stall", 32'(stall0), 32'd0);
        do_fetch(32'hBFC0_0004, 32'h2108_FFFF, 1);

        for (int i = 0; i < 10; i++) begin
            rpc = $urandom;
            if ((i % 4) == 3 && rpc[1:0] != 2'b00) do_misaligned(rpc);
            else do_fetch({rpc[31:2], 2'b00}, $urandom, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
